// File: rtl/gearbox_param_if.sv
// Handshake bundle for gearbox_param: upstream word push side, downstream word pop side, fill report.
// Optional in_flush signal present only when GB_FLUSH_EN is defined.
interface gearbox_param_if #(
  parameter int IN_W  = 256,
  parameter int OUT_W = 192
);
  localparam int FILL_W = $clog2(IN_W + OUT_W + 1);

  logic              in_enable;
  logic              out_idle;
  logic [IN_W-1:0]   in_data;
  logic              in_datavalid;
  logic              in_dataerror;
  logic [OUT_W-1:0]  out_data;
  logic              out_datavalid;
  logic              out_dataerror;
  logic              in_idle;
  logic [FILL_W-1:0] out_fill;
`ifdef GB_FLUSH_EN
  logic              in_flush;

  modport slave (
    input  in_enable, in_data, in_datavalid, in_dataerror, in_idle, in_flush,
    output out_idle, out_data, out_datavalid, out_dataerror, out_fill
  );
  modport master (
    output in_enable, in_data, in_datavalid, in_dataerror, in_idle, in_flush,
    input  out_idle, out_data, out_datavalid, out_dataerror, out_fill
  );
`else
  modport slave (
    input  in_enable, in_data, in_datavalid, in_dataerror, in_idle,
    output out_idle, out_data, out_datavalid, out_dataerror, out_fill
  );
  modport master (
    output in_enable, in_data, in_datavalid, in_dataerror, in_idle,
    input  out_idle, out_data, out_datavalid, out_dataerror, out_fill
  );
`endif
endinterface

// File: rtl/gearbox_param.sv
// LSB-first IN_W -> OUT_W width-conversion gearbox with per-bit error tracking and two-sided backpressure.
// Optional feature macro GB_FLUSH_EN: adds in_flush to emit a partial (< OUT_W) residue as a zero-padded word.
module gearbox_param #(
  parameter int IN_W  = 256,
  parameter int OUT_W = 192
) (
  input logic           clk,
  input logic           reset,
  gearbox_param_if.slave bus
);
  localparam int BUF_W  = IN_W + OUT_W;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam logic [FILL_W-1:0] IN_WF  = FILL_W'(IN_W);
  localparam logic [FILL_W-1:0] OUT_WF = FILL_W'(OUT_W);

  logic [BUF_W-1:0]  r_buf;
  logic [BUF_W-1:0]  r_err;
  logic [FILL_W-1:0] r_fill;

  logic              w_ready;
  logic              w_full;
  logic              w_flush;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;
  logic [FILL_W-1:0] w_base;
  logic [FILL_W-1:0] w_fill_nx;
  logic [BUF_W-1:0]  w_buf_sh;
  logic [BUF_W-1:0]  w_err_sh;
  logic [BUF_W-1:0]  w_buf_nx;
  logic [BUF_W-1:0]  w_err_nx;

  // Readiness looks only at registered fill, never at in_idle.
  assign w_ready = ~reset & bus.in_enable & (r_fill <= OUT_WF);
  assign w_full  = r_fill >= OUT_WF;
  assign w_push  = bus.in_datavalid & w_ready;

`ifdef GB_FLUSH_EN
  assign w_flush = bus.in_flush & (r_fill != '0) & (r_fill < OUT_WF) & ~w_push;
`else
  assign w_flush = 1'b0;
`endif

  assign w_valid = ~reset & bus.in_enable & (w_full | w_flush);
  assign w_pop   = w_valid & bus.in_idle;

  // Bits above fill are kept zero, so the low OUT_W bits already form the padded flush word.
  assign bus.out_idle      = w_ready;
  assign bus.out_datavalid = w_valid;
  assign bus.out_data      = reset ? '0   : r_buf[OUT_W-1:0];
  assign bus.out_dataerror = reset ? 1'b0 : |r_err[OUT_W-1:0];
  assign bus.out_fill      = r_fill;

  always_comb begin
    w_buf_sh  = r_buf;
    w_err_sh  = r_err;
    w_base    = r_fill;
    w_buf_nx  = r_buf;
    w_err_nx  = r_err;
    w_fill_nx = r_fill;
    if (w_pop) begin
      w_buf_sh = r_buf >> OUT_W;
      w_err_sh = r_err >> OUT_W;
      // A flushed residue is shorter than OUT_W, so the pop empties the buffer.
      w_base   = w_full ? (r_fill - OUT_WF) : '0;
    end
    w_buf_nx  = w_buf_sh;
    w_err_nx  = w_err_sh;
    w_fill_nx = w_base;
    if (w_push) begin
      w_buf_nx  = w_buf_sh | (BUF_W'(bus.in_data) << w_base);
      w_err_nx  = w_err_sh | (BUF_W'({IN_W{bus.in_dataerror}}) << w_base);
      w_fill_nx = w_base + IN_WF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf  <= '0;
      r_err  <= '0;
      r_fill <= '0;
    end else if (bus.in_enable) begin
      r_buf  <= w_buf_nx;
      r_err  <= w_err_nx;
      r_fill <= w_fill_nx;
    end
  end
endmodule

// File: tb/tb_gearbox_param.sv
// Directed bench for gearbox_param at 256->192: byte-numbered stream model checks every popped word and its error flag.
// Covers reset, nominal packing, error isolation, backpressure, freeze, mid-stream reset and (with GB_FLUSH_EN) flush.
module tb_gearbox_param;
  localparam int IN_W  = 256;
  localparam int OUT_W = 192;

  logic clk = 1'b0;
  logic reset;
  int   nasrt = 0;
  int   nfail = 0;
  int   nin   = 0;
  int   nout  = 0;
  logic [7:0] seed = 8'h00;
  bit   in_err [0:15];

  gearbox_param_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  gearbox_param #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Input word n carries stream bytes 32n..32n+31, offset by seed.
  function automatic logic [255:0] inw(int n);
    logic [255:0] r;
    for (int j = 0; j < 32; j++) r[j*8 +: 8] = seed + 8'(n*32 + j);
    return r;
  endfunction

  function automatic logic [191:0] outw(int k);
    logic [191:0] r;
    for (int j = 0; j < 24; j++) r[j*8 +: 8] = seed + 8'(k*24 + j);
    return r;
  endfunction

  function automatic logic experr(int k);
    logic r = 1'b0;
    for (int n = (24*k)/32; n <= (24*k+23)/32; n++) r |= in_err[n];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic new_stream(input logic [7:0] s);
    seed = s;
    nin  = 0;
    nout = 0;
    for (int i = 0; i < 16; i++) in_err[i] = 1'b0;
  endtask

  // One clock cycle; entered and left at posedge+1.
  task automatic cyc(input bit push, input bit err);
    bus.in_datavalid = push;
    bus.in_data      = push ? inw(nin) : '0;
    bus.in_dataerror = err;
    #1;
    if (bus.out_datavalid && bus.in_idle) begin
      chk($sformatf("data_out%0d", nout), 256'(bus.out_data), 256'(outw(nout)));
      chk($sformatf("err_out%0d", nout), 256'(bus.out_dataerror), 256'(experr(nout)));
      nout++;
    end
    if (bus.in_datavalid && bus.out_idle) begin
      in_err[nin] = err;
      nin++;
    end
    @(posedge clk);
    #1;
  endtask

  // Three words A,B,C offered back to back, then drained; fill after each cycle is hand-derived.
  task automatic abc(input int errw);
    int  fills [7] = '{256, 64, 320, 128, 384, 192, 0};
    bit  pat   [7] = '{1, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      cyc(pat[i], nin == errw);
      chk($sformatf("fill_step%0d", i), 256'(bus.out_fill), 256'(fills[i]));
      if (i == 5) begin
        chk("idle_at_192", 256'(bus.out_idle), 256'(1));
        chk("valid_at_192", 256'(bus.out_datavalid), 256'(1));
      end
    end
    chk("abc_out_count", 256'(nout), 256'(4));
  endtask

  initial begin
    reset            = 1'b1;
    bus.in_enable    = 1'b1;
    bus.in_idle      = 1'b1;
    bus.in_datavalid = 1'b0;
    bus.in_data      = '0;
    bus.in_dataerror = 1'b0;
`ifdef GB_FLUSH_EN
    bus.in_flush     = 1'b0;
`endif
    #1;
    chk("rst_idle", 256'(bus.out_idle), 256'(0));
    chk("rst_valid", 256'(bus.out_datavalid), 256'(0));
    chk("rst_data", 256'(bus.out_data), 256'(0));
    chk("rst_err", 256'(bus.out_dataerror), 256'(0));
    @(posedge clk);
    #1;
    chk("rst_fill", 256'(bus.out_fill), 256'(0));
    reset = 1'b0;
    #1;
    chk("post_rst_idle", 256'(bus.out_idle), 256'(1));

    // Nominal packing
    new_stream(8'h00);
    abc(-1);

    // Error on B only: expect 0,1,1,0
    new_stream(8'h10);
    abc(1);

    // Backpressure
    new_stream(8'h20);
    bus.in_idle = 1'b0;
    cyc(1, 0);
    chk("bp_fill_a", 256'(bus.out_fill), 256'(256));
    chk("bp_idle_lo", 256'(bus.out_idle), 256'(0));
    chk("bp_valid_hi", 256'(bus.out_datavalid), 256'(1));
    cyc(1, 0);
    chk("bp_fill_hold", 256'(bus.out_fill), 256'(256));
    chk("bp_b_held", 256'(nin), 256'(1));
    bus.in_idle = 1'b1;
    cyc(1, 0);
    chk("bp_fill_pop", 256'(bus.out_fill), 256'(64));
    chk("bp_idle_hi", 256'(bus.out_idle), 256'(1));
    cyc(1, 0);
    chk("bp_fill_b", 256'(bus.out_fill), 256'(320));
    cyc(1, 0);
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 0);
    chk("bp_fill_end", 256'(bus.out_fill), 256'(0));
    chk("bp_out_count", 256'(nout), 256'(4));

    // Freeze with a 64-bit residue
    new_stream(8'h30);
    cyc(1, 0);
    cyc(0, 0);
    chk("frz_fill_pre", 256'(bus.out_fill), 256'(64));
    bus.in_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0);
      chk("frz_fill", 256'(bus.out_fill), 256'(64));
      chk("frz_idle", 256'(bus.out_idle), 256'(0));
      chk("frz_valid", 256'(bus.out_datavalid), 256'(0));
    end
    chk("frz_no_push", 256'(nin), 256'(1));
    bus.in_enable = 1'b1;
    cyc(1, 0);
    chk("frz_fill_b", 256'(bus.out_fill), 256'(320));
    cyc(0, 0);
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 0);
    chk("frz_fill_end", 256'(bus.out_fill), 256'(0));
    chk("frz_out_count", 256'(nout), 256'(4));

    // Reset mid-stream at fill=128
    new_stream(8'h40);
    cyc(1, 0);
    cyc(0, 0);
    cyc(1, 0);
    cyc(0, 0);
    chk("mrst_fill_pre", 256'(bus.out_fill), 256'(128));
    reset = 1'b1;
    #1;
    chk("mrst_idle", 256'(bus.out_idle), 256'(0));
    chk("mrst_valid", 256'(bus.out_datavalid), 256'(0));
    chk("mrst_data", 256'(bus.out_data), 256'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mrst_fill", 256'(bus.out_fill), 256'(0));
    chk("mrst_valid_after", 256'(bus.out_datavalid), 256'(0));
    new_stream(8'h80);
    abc(-1);

`ifdef GB_FLUSH_EN
    new_stream(8'h50);
    cyc(1, 0);
    cyc(0, 0);
    chk("fl_fill_pre", 256'(bus.out_fill), 256'(64));
    bus.in_flush = 1'b1;
    #1;
    chk("fl_valid", 256'(bus.out_datavalid), 256'(1));
    chk("fl_data", 256'(bus.out_data), inw(0) >> 192);
    chk("fl_err", 256'(bus.out_dataerror), 256'(0));
    @(posedge clk);
    #1;
    bus.in_flush = 1'b0;
    chk("fl_fill_post", 256'(bus.out_fill), 256'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end
endmodule
